// File: rtl/counter_bank_pkg.sv
// -----------------------------------------------------------------------------
// counter_bank_pkg
// Shared constants for the counter bank: encoding of the per-channel
// direction input.
// -----------------------------------------------------------------------------
package counter_bank_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_bank_ch.sv
// -----------------------------------------------------------------------------
// counter_bank_ch
// One counter channel: count register, next-state logic and registered
// terminal-count pulse. Exports a combinational terminal-event flag so the
// top level can chain channels into one wide counter.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (count=0, tc=0)
//   en        in   effective count enable for this channel
//   dir       in   1 = up, 0 = down
//   load      in   synchronous load strobe (overrides en)
//   load_val  in   [WIDTH]  load value, clamped to max_val
//   max_val   in   [WIDTH]  runtime terminal value
//   count     out  [WIDTH]  registered count
//   tc        out  registered terminal-count pulse
//   term_evt  out  combinational: a terminal event happens on this edge
// -----------------------------------------------------------------------------
module counter_bank_ch
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             term_evt
);

  localparam bit SAT = (SATURATE != 0);

  // Load value never exceeds the terminal value.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] lv,
                                                  input logic [WIDTH-1:0] mv);
    return (lv < mv) ? lv : mv;
  endfunction

  // Value taken when a terminal event occurs: wrap to the opposite bound or
  // hold at the bound that was reached.
  function automatic logic [WIDTH-1:0] bound_val(input logic             up,
                                                 input logic [WIDTH-1:0] mv);
    if (SAT) return up ? mv : '0;
    else     return up ? '0 : mv;
  endfunction

  logic [WIDTH-1:0] cnt_p0;
  logic             tc_p0;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;
  logic             at_bound;

  // Stage p0: next-state and terminal detection
  always_comb begin
    inc      = count + 1'b1;
    dec      = count - 1'b1;
    // ">=" on the up side so a max_val lowered below count terminates at once.
    at_bound = (dir == DIR_UP) ? (count >= max_val) : (count == '0);
    term_evt = en & ~load & at_bound;
    cnt_p0   = count;
    tc_p0    = 1'b0;
    if (load) begin
      cnt_p0 = clamp_load(load_val, max_val);
    end else if (en) begin
      if (at_bound) begin
        cnt_p0 = bound_val(dir == DIR_UP, max_val);
        // In saturate mode the pulse fired on the arriving step, not here.
        tc_p0  = ~SAT;
      end else if (dir == DIR_UP) begin
        cnt_p0 = inc;
        tc_p0  = SAT & (inc == max_val);
      end else begin
        cnt_p0 = dec;
        tc_p0  = SAT & (dec == '0);
      end
    end
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= cnt_p0;
      tc    <= tc_p0;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// -----------------------------------------------------------------------------
// counter_bank
// NUM_CH independent WIDTH-bit counters with per-channel direction, enable,
// synchronous load, runtime terminal value and registered terminal pulse.
// SATURATE selects wrap (0) or hold-at-bound (1).
//
// Optional build macro COUNTER_BANK_CASCADE_EN: when defined, channel i>0 only
// counts on cycles where channel i-1 has a terminal event, so the channels
// behave as one wide counter rolling over in a single cycle.
//
// Ports (channel i at [i*WIDTH +: WIDTH] in packed vectors):
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   en        in   [NUM_CH]         count enable
//   dir       in   [NUM_CH]         1 = up, 0 = down
//   load      in   [NUM_CH]         synchronous load strobe
//   load_val  in   [NUM_CH*WIDTH]   load values
//   max_val   in   [NUM_CH*WIDTH]   terminal values
//   count     out  [NUM_CH*WIDTH]   registered counts
//   tc        out  [NUM_CH]         registered terminal-count pulses
// -----------------------------------------------------------------------------
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_CH   = 3,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [NUM_CH*WIDTH-1:0] max_val,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       tc
);

  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] en_eff;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef COUNTER_BANK_CASCADE_EN
    if (i == 0) begin : g_first
      assign en_eff[i] = en[i];
    end else begin : g_chain
      assign en_eff[i] = en[i] & term[i-1];
    end
`else
    assign en_eff[i] = en[i];
`endif

    counter_bank_ch #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en_eff[i]),
      .dir      (dir[i]),
      .load     (load[i]),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .max_val  (max_val[i*WIDTH +: WIDTH]),
      .count    (count[i*WIDTH +: WIDTH]),
      .tc       (tc[i]),
      .term_evt (term[i])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;

  localparam int W = 8;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           clk_run = 1'b1;
  logic           rst = 1'b1;
  logic [N-1:0]   en = '0;
  logic [N-1:0]   dir = '0;
  logic [N-1:0]   load = '0;
  logic [N*W-1:0] load_val = '0;
  logic [N*W-1:0] max_val = '0;
  logic [N*W-1:0] count_w, count_s;
  logic [N-1:0]   tc_w, tc_s;

  counter_bank #(.WIDTH(W), .NUM_CH(N), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .max_val(max_val), .count(count_w), .tc(tc_w));

  counter_bank #(.WIDTH(W), .NUM_CH(N), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .max_val(max_val), .count(count_s), .tc(tc_s));

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: [0] wrap bank, [1] saturate bank
  logic [W-1:0] m_cnt [2][N];

  typedef struct {
    logic [N*W-1:0] cnt_w;
    logic [N*W-1:0] cnt_s;
    logic [N-1:0]   tc_w;
    logic [N-1:0]   tc_s;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N; i++) m_cnt[s][i] = '0;
  endtask

  function automatic exp_t model_step();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
`ifdef COUNTER_BANK_CASCADE_EN
      logic prev_term = 1'b0;
`endif
      for (int i = 0; i < N; i++) begin
        logic [W-1:0] c, lv, mv, nc;
        logic e_i, t, term;
        c  = m_cnt[s][i];
        lv = load_val[i*W +: W];
        mv = max_val[i*W +: W];
        e_i = en[i];
`ifdef COUNTER_BANK_CASCADE_EN
        if (i > 0) e_i = e_i & prev_term;
`endif
        term = e_i & ~load[i] & (dir[i] ? (c >= mv) : (c == 0));
        t = 1'b0;
        nc = c;
        if (load[i]) nc = (lv < mv) ? lv : mv;
        else if (!e_i) nc = c;
        else if (dir[i]) begin
          if (c >= mv) begin nc = (s == 1) ? mv : 8'd0; t = (s == 0); end
          else begin nc = c + 8'd1; t = (s == 1) && (nc == mv); end
        end else begin
          if (c == 0) begin nc = (s == 1) ? 8'd0 : mv; t = (s == 0); end
          else begin nc = c - 8'd1; t = (s == 1) && (nc == 0); end
        end
        m_cnt[s][i] = nc;
        if (s == 0) begin e.cnt_w[i*W +: W] = nc; e.tc_w[i] = t; end
        else        begin e.cnt_s[i*W +: W] = nc; e.tc_s[i] = t; end
`ifdef COUNTER_BANK_CASCADE_EN
        prev_term = term;
`endif
      end
    end
    return e;
  endfunction

  // Drive is already applied; predict, clock, then compare at the falling edge.
  task automatic step(input string name);
    exp_t e;
    sb.push_back(model_step());
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({name, " count_w"}, count_w, e.cnt_w);
    chk({name, " tc_w"},    tc_w,    e.tc_w);
    chk({name, " count_s"}, count_s, e.cnt_s);
    chk({name, " tc_s"},    tc_s,    e.tc_s);
  endtask

  typedef struct {
    logic en, dir, ld;
    logic [W-1:0] lv, mv;
    logic [W-1:0] wc; logic wt;
    logic [W-1:0] sc; logic st;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic d, logic l, logic [W-1:0] lv, logic [W-1:0] mv,
                              logic [W-1:0] wc, logic wt, logic [W-1:0] sc, logic st);
    vec_t v;
    v.en = e; v.dir = d; v.ld = l; v.lv = lv; v.mv = mv;
    v.wc = wc; v.wt = wt; v.sc = sc; v.st = st;
    return v;
  endfunction

  initial begin
    // Hand-computed channel-0 vectors: en dir ld lv mv | wrap cnt tc | sat cnt tc
    tbl.push_back(mk(1,1,1,  0,  5,   0,0,   0,0));  // load 0
    tbl.push_back(mk(1,1,0,  0,  5,   1,0,   1,0));
    tbl.push_back(mk(1,1,0,  0,  5,   2,0,   2,0));
    tbl.push_back(mk(1,1,0,  0,  5,   3,0,   3,0));
    tbl.push_back(mk(1,1,0,  0,  5,   4,0,   4,0));
    tbl.push_back(mk(1,1,0,  0,  5,   5,0,   5,1));  // sat arrives at bound
    tbl.push_back(mk(1,1,0,  0,  5,   0,1,   5,0));  // wrap edge
    tbl.push_back(mk(1,1,0,  0,  5,   1,0,   5,0));
    tbl.push_back(mk(1,0,1,  1,  3,   1,0,   1,0));  // down, start 1
    tbl.push_back(mk(1,0,0,  0,  3,   0,0,   0,1));
    tbl.push_back(mk(1,0,0,  0,  3,   3,1,   0,0));
    tbl.push_back(mk(1,0,0,  0,  3,   2,0,   0,0));
    tbl.push_back(mk(1,0,1,  2,  3,   2,0,   2,0));  // down, start 2
    tbl.push_back(mk(1,0,0,  0,  3,   1,0,   1,0));
    tbl.push_back(mk(1,0,0,  0,  3,   0,0,   0,1));
    tbl.push_back(mk(1,0,0,  0,  3,   3,1,   0,0));
    tbl.push_back(mk(1,1,1,  9,  6,   6,0,   6,0));  // load clamps, overrides en
    tbl.push_back(mk(1,1,0,  0,  6,   0,1,   6,0));
    tbl.push_back(mk(0,1,0,  0,  6,   0,0,   6,0));  // hold
    tbl.push_back(mk(1,1,1, 10, 20,  10,0,  10,0));
    tbl.push_back(mk(1,1,0,  0, 20,  11,0,  11,0));
    tbl.push_back(mk(1,1,0,  0,  4,   0,1,   4,0));  // max lowered below count
    tbl.push_back(mk(1,1,1,  0,  0,   0,0,   0,0));  // max 0
    tbl.push_back(mk(1,1,0,  0,  0,   0,1,   0,0));
    tbl.push_back(mk(1,1,0,  0,  0,   0,1,   0,0));
    tbl.push_back(mk(1,0,0,  0,  0,   0,1,   0,0));
    tbl.push_back(mk(1,1,1,255,255, 255,0, 255,0));  // top of range
    tbl.push_back(mk(1,1,0,  0,255,   0,1, 255,0));

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset count_w", count_w, '0);
    chk("reset tc_w",    tc_w,    '0);
    rst = 1'b0;

    en = '1; dir = '1; max_val = {N{8'd200}};
    step("run1");
    step("run2");
    step("run3");
    chk("run3 ch0", count_w[W-1:0], 3);

    // Async reset with the clock stopped low
    clk_run = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst count_w", count_w, '0);
    chk("async rst tc_w",    tc_w,    '0);
    chk("async rst count_s", count_s, '0);
    model_reset();
    #4 rst = 1'b0;
    clk_run = 1'b1;
    step("post rst");
    chk("post rst ch0", count_w[W-1:0], 1);

    // Table vectors, same settings on every channel
    foreach (tbl[k]) begin
      en = {N{tbl[k].en}}; dir = {N{tbl[k].dir}}; load = {N{tbl[k].ld}};
      load_val = {N{tbl[k].lv}}; max_val = {N{tbl[k].mv}};
      step($sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d wc", k), count_w[W-1:0], tbl[k].wc);
      chk($sformatf("tbl%0d wt", k), tc_w[0],        tbl[k].wt);
      chk($sformatf("tbl%0d sc", k), count_s[W-1:0], tbl[k].sc);
      chk($sformatf("tbl%0d st", k), tc_s[0],        tbl[k].st);
    end

`ifdef COUNTER_BANK_CASCADE_EN
    // Cascade: ch0,ch1 max 3, ch2 max 255
    en = '1; dir = '1; load = '1; load_val = '0;
    max_val = {8'd255, 8'd3, 8'd3};
    step("casc load");
    load = '0;
    for (int k = 1; k <= 16; k++) begin
      step($sformatf("casc%0d", k));
      if (k == 4) chk("casc4 ch1", count_w[2*W-1:W], 1);
      if (k == 16) begin
        chk("casc16 ch0", count_w[W-1:0],    0);
        chk("casc16 ch1", count_w[2*W-1:W],  0);
        chk("casc16 tc",  tc_w,              3'b011);
        chk("casc16 ch2", count_w[3*W-1:2*W], 1);
      end
    end
`endif

    // Random per-channel traffic with occasional running-clock reset
    load = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        en[i]   = ($urandom_range(0, 7) != 0);
        load[i] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 5) == 0) dir[i] = ~dir[i];
        load_val[i*W +: W] = W'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) max_val[i*W +: W] = W'($urandom_range(0, 12));
      end
      if (k == 200) begin
        #1 rst = 1'b1;
        #1;
        chk("mid rst count_w", count_w, '0);
        chk("mid rst tc_s",    tc_s,    '0);
        model_reset();
        #1 rst = 1'b0;
      end
      step($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/counter_bank.md
# counter_bank

- Multi-channel, runtime-configurable counter bank.
- Generalises the team's single fixed-limit up-counter:
  - `NUM_CH` independent channels of `WIDTH` bits.
  - Per-channel up/down direction, enable, synchronous load and runtime terminal value.
  - Wrap or saturate behaviour.
  - Registered terminal-count pulse per channel.
- Sits beside the timing/pacing logic. Feeds rate dividers, timeouts and event counters.

## Interface

Parameters:
- `WIDTH`, 8: bits per channel counter.
- `NUM_CH`, 3: number of channels (≥1).
- `SATURATE`, 0: 0 = wrap at bound; 1 = hold at bound.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in `NUM_CH`: per-channel count enable.
- `dir` in `NUM_CH`: 1 = count up, 0 = count down.
- `load` in `NUM_CH`: per-channel synchronous load strobe.
- `load_val` in `NUM_CH*WIDTH`: load values; channel i at bits [i*WIDTH +: WIDTH].
- `max_val` in `NUM_CH*WIDTH`: per-channel terminal value, same packing.
- `count` out `NUM_CH*WIDTH`: registered counter values, same packing.
- `tc` out `NUM_CH`: registered terminal-count pulse.

## Operation

Per channel, evaluated every rising `clk`, in priority order:
1. **Load.** `load`=1 sets count = min(`load_val`, `max_val`) and tc=0. Load overrides `en`.
2. **Hold.** `en`=0 holds count and sets tc=0.
3. **Up** (`dir`=1):
   - If count ≥ `max_val`: terminal event. Count goes to 0 (wrap) or `max_val` (saturate).
   - Otherwise count+1.
4. **Down** (`dir`=0):
   - If count == 0: terminal event. Count goes to `max_val` (wrap) or stays at 0 (saturate).
   - Otherwise count−1.

Terminal-count pulse:
- Wrap mode: tc=1 for exactly the edge where a terminal event occurs; otherwise 0.
- Saturate mode: tc=1 only on the step that arrives at the bound (count+1 == `max_val` up; count−1 == 0 down). tc=0 while holding at the bound.

Boundary conditions:
- `max_val`=0: up-wrap toggles between 0 and 0, so tc=1 every enabled cycle.
- `max_val` lowered below the current count: the next enabled up-step is a terminal event. Down counting simply decrements.
- `dir` changes apply on the same edge. There is no pipeline state.
- Arithmetic is modulo 2^WIDTH. No carry out beyond tc.

## Timing

- Reset: all `count`=0, all `tc`=0, immediately on `rst` assertion, independent of `clk`.
- Counting resumes on the first rising edge after `rst` deasserts.
- Latency: inputs sampled at edge N; `count`/`tc` reflect them after edge N.
- tc is aligned with the wrapped `count` value.
- `rst` asserted mid-count clears everything. No partial state survives.
- All channels update on the same edge.

## Configuration

`COUNTER_BANK_CASCADE_EN`:
- **Defined:** channel i>0 uses effective enable = `en[i]` AND (terminal event of channel i−1 in the same cycle). The terminal event is combinational from channel i−1's next-state logic.
  - Channels form one wide counter that rolls over in a single cycle.
  - Channel 0 uses `en[0]` directly.
  - Load on channel i−1 produces no terminal event.
- **Undefined:** channels are fully independent and `en[i]` is used directly.

## Structure

- Package `counter_bank_pkg`: constants `DIR_UP`=1'b1 and `DIR_DOWN`=1'b0.
- Sub-module `counter_bank_ch`: one channel. It contains the register, next-state logic, and tc logic, and exports a combinational `term_evt` for cascading.
- Top level: generate loop of `NUM_CH` `counter_bank_ch` instances plus the cascade enable wiring.

## Test plan

- **Reset:** assert `rst` mid-count with `clk` stopped → `count`=0 and `tc`=0 immediately; first edge after release with en=1, dir=1 → count=1.
- **Up wrap:** WIDTH=8, `max_val`=5, en=1, dir=1 from 0 → sequence 1,2,3,4,5,0. tc=1 only on the edge producing 0. Period is 6 cycles.
- **Down and saturate:**
  - SATURATE=0, dir=0, `max_val`=3, start 1 → sequence 0, 3 (tc=1), 2.
  - SATURATE=1, dir=0, start 2 → sequence 1, 0 (tc=1), then 0 held with tc=0.
- **Load priority:** `load`=1, en=1, `load_val`=9, `max_val`=6 → count=6, tc=0; next up-step → 0 with tc=1.
- **Cascade** (`COUNTER_BANK_CASCADE_EN`): NUM_CH=2, `max_val`={3,3}, all en=1, dir=1 → channel 1 increments once per 4 clocks. Both wrap together at clock 16 with tc[0]=tc[1]=1.
- **Runtime max change:** count=10 counting up; set `max_val`=4 → next edge count=0, tc=1.
